// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: read-side AXI arbiter for icache, dcache and uncached loads.
// One AR burst outstanding; R beats gathered into a 128-bit line or 32-bit word.
module axi_rd_arbiter (
  input  logic         clk,
  input  logic         resetn,
  input  logic         icache_req,
  input  logic         icache_uncache,
  input  logic [31:0]  icache_addr,
  output logic         icache_addr_ready,
  output logic         icache_data_ready,
  output logic [127:0] icache_rdata,
  input  logic         dcache_rd_req,
  input  logic [31:0]  dcache_rd_addr,
  output logic         dcache_rd_rdy,
  output logic         dcache_ret_valid,
  output logic [127:0] dcache_ret_data,
  input  logic         uncache_rd_req,
  input  logic [2:0]   uncache_rd_size,
  input  logic [31:0]  uncache_rd_addr,
  output logic         uncache_rd_rdy,
  output logic         uncache_ret_valid,
  output logic [31:0]  uncache_ret_data,
  output logic [3:0]   arid,
  output logic [31:0]  araddr,
  output logic [7:0]   arlen,
  output logic [2:0]   arsize,
  output logic [1:0]   arburst,
  output logic [1:0]   arlock,
  output logic [3:0]   arcache,
  output logic [2:0]   arprot,
  output logic         arvalid,
  input  logic         arready,
  input  logic [3:0]   rid,
  input  logic [31:0]  rdata,
  input  logic [1:0]   rresp,
  input  logic         rlast,
  input  logic         rvalid,
  output logic         rready
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_AR   = 2'd1;
  localparam logic [1:0] S_R    = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]   r_state;
  logic [1:0]   w_next;
  logic         r_last_was_d;
  logic [3:0]   r_id;
  logic [31:0]  r_addr;
  logic [7:0]   r_len;
  logic [2:0]   r_size;
  logic [1:0]   r_burst;
  logic [1:0]   r_cnt;
  logic [127:0] r_buf;
  logic [127:0] w_buf;
  logic [127:0] r_idata;
  logic [127:0] r_ddata;
  logic [31:0]  r_udata;
  logic         w_idle;
  logic         w_gnt_u;
  logic         w_gnt_d;
  logic         w_gnt_i;
  logic         w_gnt;
  logic         w_line;
  logic         w_beat;
  logic         w_unused;

  assign w_idle  = (r_state == S_IDLE);
  // Uncached loads always win; icache/dcache alternate via r_last_was_d
  assign w_gnt_u = w_idle & uncache_rd_req;
  assign w_gnt_d = w_idle & ~uncache_rd_req & dcache_rd_req & (~r_last_was_d | ~icache_req);
  assign w_gnt_i = w_idle & ~uncache_rd_req & icache_req & (r_last_was_d | ~dcache_rd_req);
  assign w_gnt   = w_gnt_u | w_gnt_d | w_gnt_i;
  assign w_line  = w_gnt_d | (w_gnt_i & ~icache_uncache);
  assign w_beat  = (r_state == S_R) & rvalid & (rid == r_id);
  assign w_unused = &{1'b0, rresp, dcache_rd_addr[3:0]};

  assign w_next = (r_state == S_IDLE) ? (w_gnt ? S_AR : S_IDLE) :
                  (r_state == S_AR)   ? (arready ? S_R : S_AR) :
                  (r_state == S_R)    ? ((w_beat & rlast) ? S_DONE : S_R) : S_IDLE;

  always_comb begin
    w_buf = r_buf;
    w_buf[{r_cnt, 5'd0} +: 32] = rdata;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_last_was_d <= 1'b0;
      r_id         <= '0;
      r_addr       <= '0;
      r_len        <= '0;
      r_size       <= '0;
      r_burst      <= '0;
      r_cnt        <= '0;
      r_buf        <= '0;
      r_idata      <= '0;
      r_ddata      <= '0;
      r_udata      <= '0;
    end else begin
      r_state <= w_next;
      if (w_gnt_d | w_gnt_i) r_last_was_d <= w_gnt_d;
      if (w_gnt) begin
        r_id    <= w_gnt_u ? 4'd2 : w_gnt_d ? 4'd1 : 4'd0;
        r_addr  <= w_gnt_u ? uncache_rd_addr :
                   w_gnt_d ? {dcache_rd_addr[31:4], 4'd0} :
                   icache_uncache ? icache_addr : {icache_addr[31:4], 4'd0};
        r_len   <= w_line ? 8'd3 : 8'd0;
        r_size  <= w_gnt_u ? uncache_rd_size : 3'd2;
        r_burst <= 2'b01;
      end
      if (arvalid & arready) begin
        r_cnt <= '0;
        r_buf <= '0;
      end
      // Counter saturates so surplus beats keep landing in the top slot
      if (w_beat) begin
        r_buf <= w_buf;
        r_cnt <= (r_cnt == 2'd3) ? 2'd3 : r_cnt + 2'd1;
      end
      if (w_beat & rlast) begin
        if (r_id == 4'd0) r_idata <= w_buf;
        if (r_id == 4'd1) r_ddata <= w_buf;
        if (r_id == 4'd2) r_udata <= w_buf[31:0];
      end
    end
  end

  assign icache_addr_ready = w_gnt_i;
  assign dcache_rd_rdy     = w_gnt_d;
  assign uncache_rd_rdy    = w_gnt_u;
  assign icache_data_ready = (r_state == S_DONE) & (r_id == 4'd0);
  assign dcache_ret_valid  = (r_state == S_DONE) & (r_id == 4'd1);
  assign uncache_ret_valid = (r_state == S_DONE) & (r_id == 4'd2);
  assign icache_rdata      = r_idata;
  assign dcache_ret_data   = r_ddata;
  assign uncache_ret_data  = r_udata;
  assign arid    = r_id;
  assign araddr  = r_addr;
  assign arlen   = r_len;
  assign arsize  = r_size;
  assign arburst = r_burst;
  assign arlock  = 2'd0;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign arvalid = (r_state == S_AR);
  assign rready  = (r_state == S_R);
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter: table-driven requests against an AXI slave model,
// returned data checked through an expected-result queue.
module tb_axi_rd_arbiter;
  logic         clk;
  logic         resetn;
  logic         icache_req;
  logic         icache_uncache;
  logic [31:0]  icache_addr;
  logic         icache_addr_ready;
  logic         icache_data_ready;
  logic [127:0] icache_rdata;
  logic         dcache_rd_req;
  logic [31:0]  dcache_rd_addr;
  logic         dcache_rd_rdy;
  logic         dcache_ret_valid;
  logic [127:0] dcache_ret_data;
  logic         uncache_rd_req;
  logic [2:0]   uncache_rd_size;
  logic [31:0]  uncache_rd_addr;
  logic         uncache_rd_rdy;
  logic         uncache_ret_valid;
  logic [31:0]  uncache_ret_data;
  logic [3:0]   arid;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic [1:0]   arlock;
  logic [3:0]   arcache;
  logic [2:0]   arprot;
  logic         arvalid;
  logic         arready;
  logic [3:0]   rid;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rlast;
  logic         rvalid;
  logic         rready;

  axi_rd_arbiter dut (
    .clk(clk), .resetn(resetn),
    .icache_req(icache_req), .icache_uncache(icache_uncache), .icache_addr(icache_addr),
    .icache_addr_ready(icache_addr_ready), .icache_data_ready(icache_data_ready), .icache_rdata(icache_rdata),
    .dcache_rd_req(dcache_rd_req), .dcache_rd_addr(dcache_rd_addr), .dcache_rd_rdy(dcache_rd_rdy),
    .dcache_ret_valid(dcache_ret_valid), .dcache_ret_data(dcache_ret_data),
    .uncache_rd_req(uncache_rd_req), .uncache_rd_size(uncache_rd_size), .uncache_rd_addr(uncache_rd_addr),
    .uncache_rd_rdy(uncache_rd_rdy), .uncache_ret_valid(uncache_ret_valid), .uncache_ret_data(uncache_ret_data),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  typedef struct {
    int               src;
    logic             unc;
    logic [2:0]       size;
    logic [31:0]      addr;
    int               ar_dly;
    int               nb;
    logic [4:0][31:0] bd;
    logic [4:0][3:0]  bid;
    logic [4:0]       bl;
    logic [3:0]       e_id;
    logic [31:0]      e_addr;
    logic [7:0]       e_len;
    logic [2:0]       e_size;
    logic [127:0]     e_data;
  } vec_t;

  typedef struct packed {
    logic [2:0]   oh;
    logic [127:0] data;
  } exp_t;

  exp_t         exp_q[$];
  exp_t         m_e;
  logic [2:0]   m_oh;
  logic [127:0] m_d;
  int           checks = 0;
  int           errors = 0;
  vec_t         tv[5];
  vec_t         av;
  int           seq[5] = '{2, 1, 0, 1, 0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [2:0] oh(input int src);
    return (src == 2) ? 3'b100 : (src == 1) ? 3'b010 : 3'b001;
  endfunction

  function automatic vec_t mk(input int src, input logic unc, input logic [2:0] size, input logic [31:0] addr,
                              input int dly, input int nb, input logic [159:0] bd, input logic [19:0] bid,
                              input logic [4:0] bl, input logic [31:0] e_addr, input logic [127:0] e_data);
    vec_t v;
    v.src = src; v.unc = unc; v.size = size; v.addr = addr; v.ar_dly = dly; v.nb = nb;
    v.bd = bd; v.bid = bid; v.bl = bl; v.e_addr = e_addr; v.e_data = e_data;
    v.e_id = (src == 2) ? 4'd2 : (src == 1) ? 4'd1 : 4'd0;
    v.e_len = (src == 1 || (src == 0 && !unc)) ? 8'd3 : 8'd0;
    v.e_size = (src == 2) ? size : 3'd2;
    return v;
  endfunction

  function automatic vec_t arb_vec(input int src, input int k);
    vec_t v;
    v.src = src; v.unc = 1'b0; v.size = 3'd2; v.ar_dly = 1;
    v.addr = (src == 2) ? 32'h300 : (src == 1) ? 32'h208 : 32'h10c;
    v.e_addr = (src == 2) ? 32'h300 : (src == 1) ? 32'h200 : 32'h100;
    v.e_id = (src == 2) ? 4'd2 : (src == 1) ? 4'd1 : 4'd0;
    v.e_len = (src == 2) ? 8'd0 : 8'd3;
    v.e_size = 3'd2;
    v.nb = (src == 2) ? 1 : 4;
    v.bd = '0; v.bid = '0; v.bl = '0; v.e_data = '0;
    for (int j = 0; j < v.nb; j++) begin
      v.bd[j] = 32'(k * 256 + j + 1);
      v.bid[j] = v.e_id;
      v.e_data[32*j +: 32] = v.bd[j];
    end
    v.bl[v.nb-1] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (resetn && (icache_data_ready || dcache_ret_valid || uncache_ret_valid)) begin
      m_oh = {uncache_ret_valid, dcache_ret_valid, icache_data_ready};
      m_d = uncache_ret_valid ? {96'd0, uncache_ret_data} : dcache_ret_valid ? dcache_ret_data : icache_rdata;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL ret_unexpected: got valids %b data %h expected no return", m_oh, m_d);
      end else begin
        m_e = exp_q.pop_front();
        if ({m_oh, m_d} !== m_e) begin
          errors++;
          $display("FAIL ret_data: got %b/%h expected %b/%h", m_oh, m_d, m_e.oh, m_e.data);
        end
      end
    end
  end

  task automatic issue(input vec_t v);
    @(negedge clk);
    icache_req = (v.src == 0); icache_uncache = v.unc; icache_addr = v.addr;
    dcache_rd_req = (v.src == 1); dcache_rd_addr = v.addr;
    uncache_rd_req = (v.src == 2); uncache_rd_size = v.size; uncache_rd_addr = v.addr;
    #1;
    chk("grant", {uncache_rd_rdy, dcache_rd_rdy, icache_addr_ready}, oh(v.src));
    exp_q.push_back({oh(v.src), v.e_data});
    @(negedge clk);
    icache_req = 1'b0; dcache_rd_req = 1'b0; uncache_rd_req = 1'b0;
  endtask

  task automatic do_slave(input vec_t v);
    int n = 0;
    while (!arvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("arvalid", arvalid, 1);
    for (int j = 0; j <= v.ar_dly; j++) begin
      chk("ar_hold", {arvalid, araddr, arid, arlen, arsize, arburst, uncache_rd_rdy, dcache_rd_rdy, icache_addr_ready},
          {1'b1, v.e_addr, v.e_id, v.e_len, v.e_size, 2'b01, 3'b000});
      if (j == v.ar_dly) arready = 1'b1;
      @(negedge clk);
    end
    arready = 1'b0;
    chk("r_phase", {arvalid, rready}, 2'b01);
    for (int j = 0; j < v.nb; j++) begin
      rvalid = 1'b1; rid = v.bid[j]; rdata = v.bd[j]; rlast = v.bl[j];
      @(negedge clk);
    end
    rvalid = 1'b0; rlast = 1'b0;
    @(negedge clk);
    chk("ret_pending", 128'(exp_q.size()), 0);
  endtask

  task automatic run_vec(input vec_t v);
    issue(v);
    do_slave(v);
  endtask

  initial begin
    tv[0] = mk(1, 1'b0, 3'd2, 32'h1fc0_0024, 0, 4, {32'h0, 32'h44, 32'h33, 32'h22, 32'h11}, {5{4'h1}}, 5'b01000,
               32'h1fc0_0020, {32'h44, 32'h33, 32'h22, 32'h11});
    tv[1] = mk(2, 1'b0, 3'd1, 32'hbfaf_8002, 5, 1, {128'h0, 32'hdead}, {5{4'h2}}, 5'b00001,
               32'hbfaf_8002, 128'h0000dead);
    tv[2] = mk(0, 1'b1, 3'd2, 32'hbfc0_0004, 0, 1, {128'h0, 32'h3c08bfaf}, {5{4'h0}}, 5'b00001,
               32'hbfc0_0004, 128'h3c08bfaf);
    tv[3] = mk(1, 1'b0, 3'd2, 32'h0000_1238, 1, 5, {32'ha4, 32'ha3, 32'hbad, 32'ha2, 32'ha1},
               {4'h1, 4'h1, 4'h3, 4'h1, 4'h1}, 5'b10100, 32'h0000_1230, {32'ha4, 32'ha3, 32'ha2, 32'ha1});
    tv[4] = mk(0, 1'b0, 3'd2, 32'h8000_0014, 2, 4, {32'h0, 32'hd4, 32'hc3, 32'hb2, 32'ha1}, {5{4'h0}}, 5'b01000,
               32'h8000_0010, {32'hd4, 32'hc3, 32'hb2, 32'ha1});
    resetn = 1'b0; arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rid = '0; rdata = '0; rresp = '0;
    icache_req = 1'b0; icache_uncache = 1'b0; icache_addr = '0;
    dcache_rd_req = 1'b0; dcache_rd_addr = '0;
    uncache_rd_req = 1'b0; uncache_rd_size = '0; uncache_rd_addr = '0;
    repeat (2) @(negedge clk);
    chk("reset_ctrl", {arvalid, rready, icache_addr_ready, dcache_rd_rdy, uncache_rd_rdy,
                       icache_data_ready, dcache_ret_valid, uncache_ret_valid}, 0);
    chk("reset_ar", {araddr, arid, arlen, arsize, arburst, arlock, arcache, arprot}, 0);
    chk("reset_data", icache_rdata | dcache_ret_data | {96'd0, uncache_ret_data}, 0);
    resetn = 1'b1;
    for (int i = 0; i < 5; i++) run_vec(tv[i]);
    issue(tv[0]);
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    for (int j = 0; j < 2; j++) begin
      rvalid = 1'b1; rid = 4'h1; rdata = tv[0].bd[j]; rlast = 1'b0;
      @(negedge clk);
    end
    rdata = tv[0].bd[2];
    resetn = 1'b0;
    #1;
    chk("reset_mid_ctrl", {arvalid, rready, dcache_ret_valid, dcache_rd_rdy}, 0);
    chk("reset_mid_ar", {araddr, arid, arlen}, 0);
    chk("reset_mid_data", dcache_ret_data, 0);
    exp_q.delete();
    rvalid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    run_vec(tv[4]);
    @(negedge clk);
    icache_req = 1'b1; icache_uncache = 1'b0; icache_addr = 32'h10c;
    dcache_rd_req = 1'b1; dcache_rd_addr = 32'h208;
    uncache_rd_req = 1'b1; uncache_rd_size = 3'd2; uncache_rd_addr = 32'h300;
    for (int k = 0; k < 5; k++) begin
      #1;
      av = arb_vec(seq[k], k);
      chk("arb_grant", {uncache_rd_rdy, dcache_rd_rdy, icache_addr_ready}, oh(seq[k]));
      exp_q.push_back({oh(seq[k]), av.e_data});
      @(negedge clk);
      if (seq[k] == 2) uncache_rd_req = 1'b0;
      do_slave(av);
    end
    icache_req = 1'b0; dcache_rd_req = 1'b0;
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
